// File: rtl/cnn_job_sequencer.sv
// Job sequencer: streams filter then IFmap words into the CNN buffers, pulses start, drains results.
// Define CNN_SEQ_TIMEOUT_EN to add a DRAIN watchdog that aborts the job with error=1.
module cnn_job_sequencer #(
    parameter int IFMAP_BUFFER_WIDTH  = 18,
    parameter int FILTER_BUFFER_WIDTH = 16,
    parameter int RESULT_BUFFER_WIDTH = 16,
    parameter int COUNT_WIDTH         = 8,
    parameter int STRIDE_WIDTH        = 5,
    parameter int FILTER_SIZE_WIDTH   = 5,
    parameter int TIMEOUT_CYCLES      = 4096
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           job_valid,
    output logic                           job_ready,
    input  logic [COUNT_WIDTH-1:0]         job_filter_words,
    input  logic [COUNT_WIDTH-1:0]         job_ifmap_words,
    input  logic [COUNT_WIDTH-1:0]         job_result_words,
    input  logic [STRIDE_WIDTH-1:0]        job_stride,
    input  logic [FILTER_SIZE_WIDTH-1:0]   job_filter_size,
    input  logic                           job_psum_mode,
    output logic [STRIDE_WIDTH-1:0]        stride,
    output logic [FILTER_SIZE_WIDTH-1:0]   filter_size,
    output logic                           psum_mode,
    output logic                           start,
    input  logic                           stall_signal,
    input  logic                           src_valid,
    output logic                           src_ready,
    input  logic [IFMAP_BUFFER_WIDTH-1:0]  src_data,
    output logic                           IFmap_buffer_write_enable,
    output logic [IFMAP_BUFFER_WIDTH-1:0]  IFmap_buffer_in,
    input  logic                           IFmap_buffer_ready,
    output logic                           filter_buffer_write_enable,
    output logic [FILTER_BUFFER_WIDTH-1:0] filter_buffer_in,
    input  logic                           filter_buffer_ready,
    output logic                           result_buffer_read_enable,
    input  logic [RESULT_BUFFER_WIDTH-1:0] result_buffer_out,
    input  logic                           result_buffer_valid,
    input  logic                           result_buffer_empty,
    output logic                           out_valid,
    output logic [RESULT_BUFFER_WIDTH-1:0] out_data,
    input  logic                           out_ready,
    output logic                           busy,
    output logic                           done,
    output logic                           error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_LOAD_FILT,
        S_LOAD_IF,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                 state;
    logic [COUNT_WIDTH-1:0] filt_rem;
    logic [COUNT_WIDTH-1:0] if_rem;
    logic [COUNT_WIDTH-1:0] res_target;
    logic [COUNT_WIDTH-1:0] res_cnt;

    logic in_filt;
    logic in_if;
    logic in_drain;
    logic filt_xfer;
    logic if_xfer;
    logic capture;
    logic out_pop;
    logic drain_complete;
    logic timeout_hit;

    assign in_filt  = (state == S_LOAD_FILT);
    assign in_if    = (state == S_LOAD_IF);
    assign in_drain = (state == S_DRAIN);

    assign job_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign start     = (state == S_START);
    assign done      = (state == S_DONE);

    assign filter_buffer_write_enable = in_filt && src_valid && !stall_signal;
    assign IFmap_buffer_write_enable  = in_if && src_valid && !stall_signal;
    assign filter_buffer_in = in_filt ? src_data[FILTER_BUFFER_WIDTH-1:0] : '0;
    assign IFmap_buffer_in  = in_if ? src_data : '0;
    assign src_ready = !stall_signal &&
                       ((in_filt && filter_buffer_ready) || (in_if && IFmap_buffer_ready));

    assign filt_xfer = filter_buffer_write_enable && filter_buffer_ready;
    assign if_xfer   = IFmap_buffer_write_enable && IFmap_buffer_ready;

    // Reads stop once the job's result count is reached so the next job's words stay buffered.
    assign out_pop = out_valid && out_ready;
    assign result_buffer_read_enable = in_drain && !result_buffer_empty &&
                                       (!out_valid || out_ready) && (res_cnt != res_target);
    assign capture        = in_drain && result_buffer_valid;
    assign drain_complete = (res_cnt == res_target) && !out_valid;

`ifdef CNN_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_expired;

    assign wd_expired  = in_drain && !capture && (wd_cnt == WD_LAST);
    assign timeout_hit = wd_expired && !drain_complete;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
            error  <= 1'b0;
        end else begin
            if (!in_drain || capture || wd_expired) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (job_ready && job_valid) begin
                error <= 1'b0;
            end else if (timeout_hit) begin
                error <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign error       = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            filt_rem    <= '0;
            if_rem      <= '0;
            res_target  <= '0;
            res_cnt     <= '0;
            stride      <= '0;
            filter_size <= '0;
            psum_mode   <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
        end else begin
            if (capture) begin
                out_data  <= result_buffer_out;
                out_valid <= 1'b1;
                res_cnt   <= res_cnt + 1'b1;
            end else if (out_pop) begin
                out_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (job_valid) begin
                        filt_rem    <= job_filter_words;
                        if_rem      <= job_ifmap_words;
                        res_target  <= job_result_words;
                        res_cnt     <= '0;
                        stride      <= job_stride;
                        filter_size <= job_filter_size;
                        psum_mode   <= job_psum_mode;
                        state       <= S_START;
                    end
                end
                S_START: begin
                    if (filt_rem != '0) begin
                        state <= S_LOAD_FILT;
                    end else if (if_rem != '0) begin
                        state <= S_LOAD_IF;
                    end else begin
                        state <= S_DRAIN;
                    end
                end
                S_LOAD_FILT: begin
                    if (filt_xfer) begin
                        filt_rem <= filt_rem - 1'b1;
                        if (filt_rem == COUNT_WIDTH'(1)) begin
                            state <= (if_rem != '0) ? S_LOAD_IF : S_DRAIN;
                        end
                    end
                end
                S_LOAD_IF: begin
                    if (if_xfer) begin
                        if_rem <= if_rem - 1'b1;
                        if (if_rem == COUNT_WIDTH'(1)) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_complete || timeout_hit) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cnn_job_sequencer.md
CNN_JOB_SEQUENCER -- requirements
Module: cnn_job_sequencer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- IFMAP_BUFFER_WIDTH, 18, source and IFmap word width.
- FILTER_BUFFER_WIDTH, 16, filter word width.
- RESULT_BUFFER_WIDTH, 16, result word width.
- COUNT_WIDTH, 8, width of per-job word counts.
- STRIDE_WIDTH, 5, stride width.
- FILTER_SIZE_WIDTH, 5, filter size width.
- TIMEOUT_CYCLES, 4096, watchdog limit.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, the single clock.
- reset, in, 1, asynchronous, active-low.
- job_valid, in, 1, job request.
- job_ready, out, 1, sequencer idle and accepting a job.
- job_filter_words, in, COUNT_WIDTH, filter words in the job.
- job_ifmap_words, in, COUNT_WIDTH, IFmap words in the job.
- job_result_words, in, COUNT_WIDTH, result words expected.
- job_stride, in, STRIDE_WIDTH, stride for the job.
- job_filter_size, in, FILTER_SIZE_WIDTH, filter size for the job.
- job_psum_mode, in, 1, psum mode for the job.
- stride, out, STRIDE_WIDTH, latched stride to the CNN.
- filter_size, out, FILTER_SIZE_WIDTH, latched filter size to the CNN.
- psum_mode, out, 1, latched psum mode to the CNN.
- start, out, 1, one-cycle CNN start pulse.
- stall_signal, in, 1, CNN stall.
- src_valid, in, 1, source word valid.
- src_ready, out, 1, source word consumed.
- src_data, in, IFMAP_BUFFER_WIDTH, source word.
- IFmap_buffer_write_enable, out, 1, IFmap write request.
- IFmap_buffer_in, out, IFMAP_BUFFER_WIDTH, IFmap write data.
- IFmap_buffer_ready, in, 1, IFmap buffer accepts a word.
- filter_buffer_write_enable, out, 1, filter write request.
- filter_buffer_in, out, FILTER_BUFFER_WIDTH, filter write data.
- filter_buffer_ready, in, 1, filter buffer accepts a word.
- result_buffer_read_enable, out, 1, result read request.
- result_buffer_out, in, RESULT_BUFFER_WIDTH, result data.
- result_buffer_valid, in, 1, result_buffer_out valid this cycle.
- result_buffer_empty, in, 1, result buffer empty.
- out_valid, out, 1, output word valid.
- out_data, out, RESULT_BUFFER_WIDTH, output word.
- out_ready, in, 1, downstream accepts the output word.
- busy, out, 1, state is not IDLE.
- done, out, 1, one-cycle pulse at job end.
- error, out, 1, job aborted by the watchdog.

Function
REQ-003 States: IDLE, START, LOAD_FILT, LOAD_IF, DRAIN, DONE.
REQ-004 job_ready is 1 only in IDLE. Job accepted on a clock with job_valid && job_ready. Counts and config are latched at acceptance and drive stride, filter_size and psum_mode until the next acceptance. IDLE -> START.
REQ-005 START lasts exactly one cycle with start=1. Next state is LOAD_FILT if the filter count is nonzero, else LOAD_IF if the IFmap count is nonzero, else DRAIN.
REQ-006 LOAD_FILT handshake:
- filter_buffer_write_enable = src_valid && !stall_signal.
- filter_buffer_in = src_data[FILTER_BUFFER_WIDTH-1:0].
- src_ready = filter_buffer_ready && !stall_signal.
- A transfer occurs on a clock with all three of src_valid, filter_buffer_ready and !stall_signal high, and decrements the remaining filter count.
REQ-007 After the last filter transfer, go to LOAD_IF (IFmap count nonzero) or DRAIN. LOAD_IF is identical to LOAD_FILT using the IFmap signals and the full src_data; after its last transfer go to DRAIN.
REQ-008 Write enables and src_ready are 0 outside their own load state. The two write enables are never both 1.
REQ-009 DRAIN handshake:
- result_buffer_read_enable = !result_buffer_empty && output register empty (or being emptied this cycle).
- On each clock with result_buffer_valid, capture result_buffer_out into the output register, set out_valid, and increment the received count.
- out_valid clears on out_valid && out_ready unless a new word is captured on the same clock.
REQ-010 Result words arriving while out_valid=1 and out_ready=0 are never dropped; read_enable is withheld so this cannot happen.
REQ-011 When the received count equals the job result count and out_valid=0, go to DONE. A result count of 0 goes to DONE immediately.
REQ-012 DONE lasts one cycle with done=1, then returns to IDLE.
REQ-013 Count compare is exact at COUNT_WIDTH bits; a count of 2^COUNT_WIDTH-1 is legal.

Reset
REQ-014 On reset low, asynchronously: state=IDLE and all counters cleared. Every output is 0 except job_ready=1. stride, filter_size and psum_mode reset to 0.
REQ-015 Reset mid-job abandons the job with no done pulse. The first job after release behaves as in REQ-004.

Configuration
REQ-016 Macro CNN_SEQ_TIMEOUT_EN, when defined:
- A watchdog in DRAIN counts cycles without a result capture and resets on each capture.
- On reaching TIMEOUT_CYCLES it forces DONE with error=1.
- error holds until the next job acceptance.
REQ-017 When CNN_SEQ_TIMEOUT_EN is undefined: no watchdog logic, error tied to 0, and DRAIN waits indefinitely.

Verification
REQ-018 The bench covers these directed scenarios:
- Job filt=16, if=16, res=16, stride=4, fsize=4 with src always valid and buffers always ready -> start is 1 for exactly one cycle; 16 filter writes, then 16 IFmap writes; 16 out words; done pulse; job_ready back to 1.
- filter_buffer_ready toggling, plus a 50-cycle src_valid gap after word 5 -> no word lost or duplicated, and write order matches the source.
- stall_signal held high for 20 cycles during LOAD_IF -> no writes and src_ready=0 throughout; loading resumes when stall drops.
- out_ready=0 for 30 cycles during DRAIN -> read_enable=0 while the output register is full; all 16 results delivered in order.
- Job counts all 0 -> START, then DRAIN, then DONE; done asserts 3 cycles after acceptance.
- reset low mid-LOAD_IF -> all outputs reset immediately; the next job completes normally. With CNN_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=64, no results -> error=1 and done pulse 64 cycles after entering DRAIN.
